redmule_mx_decoder: RTL

// - Inverse of the RedMulE MX encoder. Takes the MX element stream (FP8 E4M3 lanes) and the shared-exponent stream (E8M0).
// - Rebuilds FP16 lanes as: fp16 = e4m3 * 2^(scale-127).
// - Sits between the streamer and the datapath, so MX-packed operands can be consumed from TCDM.

---
 rtl/redmule_pkg.sv | 18 +
 rtl/redmule_mx_fp8_to_fp16.sv | 71 +++++++
 rtl/redmule_mx_decoder.sv | 95 +++++++++
 3 files changed

// File: rtl/redmule_pkg.sv
// Shared constants and types for the RedMulE MX (microscaling) datapath blocks.
package redmule_pkg;

    localparam int unsigned MX_BLOCK_SIZE = 32;

    localparam int unsigned E4M3_BIAS = 7;
    localparam int unsigned FP16_BIAS = 15;
    localparam int unsigned E8M0_BIAS = 127;

    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    localparam logic [14:0] FP16_MAXN = 15'h7BFF;

    typedef enum logic [0:0] {
        WAIT_EXP = 1'b0,
        DECODE   = 1'b1
    } mx_dec_state_e;

endpackage

// File: rtl/redmule_mx_fp8_to_fp16.sv
// One-lane combinational converter: E4M3 element scaled by an E8M0 exponent into FP16.
// MX_DECODER_SUBNORM_EN selects gradual underflow (RNE) instead of flush-to-zero.
module redmule_mx_fp8_to_fp16
    import redmule_pkg::*;
(
    input  logic [7:0]  fp8,
    input  logic [7:0]  scale,
    output logic [15:0] fp16
);

    localparam logic signed [9:0] E4M3_B = 10'(E4M3_BIAS);
    localparam logic signed [9:0] E8M0_B = 10'(E8M0_BIAS);

    logic              sign;
    logic [3:0]        exp8;
    logic [2:0]        man;
    logic [1:0]        norm_sh;
    logic [3:0]        norm;
    logic [2:0]        frac;
    logic signed [9:0] exp_fp8;
    logic signed [9:0] exp_unb;
    logic [4:0]        exp_b;
`ifdef MX_DECODER_SUBNORM_EN
    logic [3:0]        sub_sh;
    logic [20:0]       sub_wide;
    logic              sub_round;
    logic [14:0]       sub_mag;
`endif

    assign sign = fp8[7];
    assign exp8 = fp8[6:3];
    assign man  = fp8[2:0];

    always_comb begin
        // FP8 subnormals: shift until the leading one becomes the hidden bit
        norm_sh = man[2] ? 2'd1 : (man[1] ? 2'd2 : 2'd3);
        norm    = {1'b0, man} << norm_sh;
        if (exp8 == 4'd0) begin
            exp_fp8 = 10'sd1 - E4M3_B - $signed({8'b0, norm_sh});
            frac    = norm[2:0];
        end else begin
            exp_fp8 = $signed({6'b0, exp8}) - E4M3_B;
            frac    = man;
        end
        exp_unb = exp_fp8 + $signed({2'b0, scale}) - E8M0_B;
        exp_b   = exp_unb[4:0] + 5'(FP16_BIAS);
`ifdef MX_DECODER_SUBNORM_EN
        sub_sh    = 4'(-10'sd14 - exp_unb);
        sub_wide  = {1'b1, frac, 17'b0} >> sub_sh;
        sub_round = sub_wide[9] && ((|sub_wide[8:0]) || sub_wide[10]);
        sub_mag   = {4'b0, sub_wide[20:10]} + {14'b0, sub_round};
`endif

        fp16 = {sign, 15'b0};
        if (scale == 8'hFF || fp8[6:0] == 7'h7F) begin
            fp16 = FP16_QNAN;
        end else if (fp8[6:0] == 7'h00) begin
            fp16 = {sign, 15'b0};
        end else if (exp_unb > 10'sd15) begin
            fp16 = {sign, FP16_MAXN};
        end else if (exp_unb >= -10'sd14) begin
            fp16 = {sign, exp_b, frac, 7'b0};
`ifdef MX_DECODER_SUBNORM_EN
        end else if (exp_unb >= -10'sd24) begin
            // a carry out of the mantissa lands exactly on the min normal
            fp16 = {sign, sub_mag};
`endif
        end
    end

endmodule

// File: rtl/redmule_mx_decoder.sv
// MX decoder: pairs E8M0 shared exponents with E4M3 element beats and emits FP16 beats.
// Optional gradual underflow via MX_DECODER_SUBNORM_EN (see redmule_mx_fp8_to_fp16).
module redmule_mx_decoder
    import redmule_pkg::*;
#(
    parameter int unsigned NUM_ELEMS  = 8,
    parameter int unsigned BLOCK_SIZE = MX_BLOCK_SIZE,
    parameter int unsigned EXP_W      = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    exp_valid_i,
    output logic                    exp_ready_o,
    input  logic [EXP_W-1:0]        exp_data_i,
    input  logic                    val_valid_i,
    output logic                    val_ready_o,
    input  logic [8*NUM_ELEMS-1:0]  val_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [16*NUM_ELEMS-1:0] out_data_o,
    output logic                    busy_o
);

    localparam int unsigned BEATS = BLOCK_SIZE / NUM_ELEMS;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    mx_dec_state_e           state_q;
    logic [CNT_W-1:0]        beat_cnt_q;
    logic [7:0]              scale_q;
    logic                    out_valid_q;
    logic [16*NUM_ELEMS-1:0] out_data_q;
    logic [16*NUM_ELEMS-1:0] conv_data;
    logic                    val_fire;
    logic                    exp_fire;
    logic                    last_beat;
    logic                    unused_exp_bits;

    assign unused_exp_bits = ^exp_data_i[EXP_W-1:8];

    for (genvar i = 0; i < NUM_ELEMS; i++) begin : g_lane
        redmule_mx_fp8_to_fp16 u_cvt (
            .fp8   (val_data_i[8*i+:8]),
            .scale (scale_q),
            .fp16  (conv_data[16*i+:16])
        );
    end

    assign val_ready_o = (state_q == DECODE) && (!out_valid_q || out_ready_i);
    assign val_fire    = val_valid_i && val_ready_o;
    assign last_beat   = (beat_cnt_q == LAST_BEAT);
    // next exponent is taken together with the last beat so blocks chain without a bubble
    assign exp_ready_o = (state_q == WAIT_EXP) || (val_fire && last_beat);
    assign exp_fire    = exp_valid_i && exp_ready_o;

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = (state_q == DECODE) || out_valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= WAIT_EXP;
            beat_cnt_q  <= '0;
            scale_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (clear_i) begin
            state_q     <= WAIT_EXP;
            beat_cnt_q  <= '0;
            scale_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (exp_fire) begin
                scale_q <= exp_data_i[7:0];
                state_q <= DECODE;
            end else if (val_fire && last_beat) begin
                state_q <= WAIT_EXP;
            end

            if (val_fire) begin
                beat_cnt_q <= last_beat ? '0 : beat_cnt_q + 1'b1;
            end

            if (val_fire) begin
                out_valid_q <= 1'b1;
                out_data_q  <= conv_data;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule
